// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - sizing and saturation-bound helpers shared by the multi-operand adder
package adder_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int tree_levels(input int n_ops);
      return clog2(n_ops);
   endfunction

   function automatic int sum_width(input int width, input int n_ops);
      return width + clog2(n_ops);
   endfunction

   // Partial sums held at level l, and where level l starts in the flattened tree bus.
   function automatic int tree_count(input int n_ops, input int l);
      return (n_ops + (1 << l) - 1) >> l;
   endfunction

   function automatic int tree_offset(input int n_ops, input int l);
      int o;
      o = 0;
      for (int i = 0; i < l; i++) o += tree_count(n_ops, i);
      return o;
   endfunction

   function automatic logic [63:0] sat_umax(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_smax(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_smin(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise reduction level of the adder tree
module adder_tree_level #(
   parameter int N_IN = 3,
   parameter int SUMW = 18
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             in_valid,
   input  logic                             in_signed,
   input  logic [N_IN*SUMW-1:0]             din,
   output logic                             out_valid,
   output logic                             out_signed,
   output logic [((N_IN+1)/2)*SUMW-1:0]     dout
);
   localparam int N_OUT = (N_IN + 1) / 2;

   logic [N_OUT*SUMW-1:0] nxt;

   // The last slot of an odd-sized level has no partner and is carried through as-is.
   for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      if (2*j + 1 < N_IN) begin : g_add
         assign nxt[j*SUMW +: SUMW] = din[2*j*SUMW +: SUMW] + din[(2*j+1)*SUMW +: SUMW];
      end else begin : g_pass
         assign nxt[j*SUMW +: SUMW] = din[2*j*SUMW +: SUMW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_signed <= 1'b0;
         dout       <= '0;
      end else if (en) begin
         out_valid  <= in_valid;
         out_signed <= in_signed;
         dout       <= nxt;
      end
   end

endmodule

// File: rtl/multi_adder_datapath.sv
// rtl/multi_adder_datapath.sv - pipelined N-operand adder with wrap/saturate output and valid/ready flow control
module multi_adder_datapath
   import adder_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int N_OPS    = 3,
   parameter int SATURATE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_OPS*WIDTH-1:0] ops,
   input  logic                   signed_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       y,
   output logic                   ovf
);
   localparam int LEVELS = tree_levels(N_OPS);
   localparam int SUMW   = sum_width(WIDTH, N_OPS);
   localparam int TOTAL  = tree_offset(N_OPS, LEVELS + 1);

   localparam logic [63:0]      UMAX64 = sat_umax(WIDTH);
   localparam logic [63:0]      SMAX64 = sat_smax(WIDTH);
   localparam logic [63:0]      SMIN64 = sat_smin(WIDTH);
   localparam logic [WIDTH-1:0] UMAX   = UMAX64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SMAX   = SMAX64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SMIN   = SMIN64[WIDTH-1:0];

   // Every tree level lives back-to-back in one bus so each bit has exactly one driver and one reader.
   logic [TOTAL*SUMW-1:0] bus;
   logic [LEVELS:0]       lvl_valid;
   logic [LEVELS:0]       lvl_signed;
   logic                  advance;

   assign advance       = !out_valid || out_ready;
   assign in_ready      = advance;
   assign lvl_valid[0]  = in_valid;
   assign lvl_signed[0] = signed_mode;

   for (genvar k = 0; k < N_OPS; k++) begin : g_ext
      logic [WIDTH-1:0] op;
      assign op = ops[k*WIDTH +: WIDTH];
      assign bus[k*SUMW +: SUMW] = {{LEVELS{signed_mode & op[WIDTH-1]}}, op};
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int CIN  = tree_count(N_OPS, l);
      localparam int COUT = tree_count(N_OPS, l + 1);
      localparam int OIN  = tree_offset(N_OPS, l);
      localparam int OOUT = tree_offset(N_OPS, l + 1);
      adder_tree_level #(.N_IN(CIN), .SUMW(SUMW)) u_level (
         .clk        (clk),
         .rst        (rst),
         .en         (advance),
         .in_valid   (lvl_valid[l]),
         .in_signed  (lvl_signed[l]),
         .din        (bus[OIN*SUMW +: CIN*SUMW]),
         .out_valid  (lvl_valid[l+1]),
         .out_signed (lvl_signed[l+1]),
         .dout       (bus[OOUT*SUMW +: COUT*SUMW])
      );
   end

   logic [SUMW-1:0]  sum;
   logic [LEVELS:0]  sign_bits;
   logic             ovf_n;
   logic [WIDTH-1:0] y_n;

   assign sum       = bus[tree_offset(N_OPS, LEVELS)*SUMW +: SUMW];
   assign sign_bits = sum[SUMW-1:WIDTH-1];

   // Signed fit means every bit from the WIDTH sign position upward agrees.
   always_comb begin
      ovf_n = 1'b0;
      y_n   = sum[WIDTH-1:0];
      if (lvl_signed[LEVELS]) ovf_n = !((&sign_bits) || !(|sign_bits));
      else                    ovf_n = |sum[SUMW-1:WIDTH];
      if (SATURATE != 0 && ovf_n) begin
         if (!lvl_signed[LEVELS]) y_n = UMAX;
         else if (sum[SUMW-1])    y_n = SMIN;
         else                     y_n = SMAX;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         ovf       <= 1'b0;
      end else if (advance) begin
         out_valid <= lvl_valid[LEVELS];
         y         <= y_n;
         ovf       <= ovf_n;
      end
   end

endmodule

// File: doc/multi_adder_datapath.md
# multi_adder_datapath

Parametrised, pipelined multi-operand adder. It sums N_OPS operands of WIDTH bits through a registered pairwise adder tree, then applies signed or unsigned wrap or saturation in a final output stage. A valid/ready handshake on both sides allows back-pressure. It is the next-generation adder datapath, replacing the fixed three-input, 16-bit, free-running adder.

## Interface
- `WIDTH`, default 16: operand and result width in bits, minimum 2.
- `N_OPS`, default 3: number of operands, minimum 2.
- `SATURATE`, default 0: 0 means the result wraps to WIDTH bits; 1 means the result clamps to the representable range.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: the operand vector is valid.
- `in_ready` output, 1 bit: the block accepts the vector this cycle.
- `ops` input, N_OPS*WIDTH bits: operand k occupies bits [k*WIDTH +: WIDTH].
- `signed_mode` input, 1 bit: 1 means two's-complement operands. Captured with the vector.
- `out_valid` output, 1 bit: `y` and `ovf` are valid.
- `out_ready` input, 1 bit: the downstream consumer takes the result.
- `y` output, WIDTH bits: the sum after wrap or saturation.
- `ovf` output, 1 bit: the full-precision sum did not fit in WIDTH bits, in the selected signedness.

## Operation
- Definitions:
  - LEVELS = clog2(N_OPS).
  - SUMW = WIDTH + LEVELS. This is the full-precision internal width.
- Operand extension: each operand is sign-extended to SUMW bits if `signed_mode`=1, otherwise zero-extended.
- Adder tree:
  - At each level, pairs are added and registered.
  - An odd operand at any level passes through a register unchanged.
  - Level L holds ceil(N_OPS/2^L) partial sums.
- Output stage, one register stage:
  - Computes `ovf` by range-checking the SUMW-bit sum against the WIDTH range for the current signedness.
  - Unsigned range is 0 to 2^WIDTH-1. Signed range is -2^(WIDTH-1) to 2^(WIDTH-1)-1.
- Value of `y`:
  - If `SATURATE`=0, `y` is the low WIDTH bits of the sum.
  - If `SATURATE`=1 and `ovf`=1, `y` is the range maximum on positive overflow or the minimum on negative overflow. Unsigned underflow is impossible.
- Signedness: `signed_mode` travels down the pipeline alongside its data.
- Handshake:
  - advance = !out_valid || out_ready.
  - `in_ready` = advance.
  - All stage registers and the valid bit of each stage load only when advance=1.
  - A transfer occurs on any edge where the valid and ready signals of that side are both 1.
- Bubbles: invalid slots propagate as bubbles. Bubbles are not collapsed.
- Stability under stall: while out_valid=1 and out_ready=0, `y`, `ovf` and out_valid hold stable, and `in_ready`=0.

## Timing
- Latency: a vector accepted at edge T appears with out_valid=1 after edge T+LEVELS+1, when there is no stall. This is 3 cycles for N_OPS=3.
- Throughput: one vector per cycle while out_ready=1.
- Reset:
  - All stage valid bits clear, out_valid=0, `y`=0, `ovf`=0.
  - `in_ready`=1 from the first cycle after reset.
- Reset mid-operation: all in-flight results are discarded and none emerge afterwards. A vector presented in the same cycle as `rst`=1 is not accepted.
- Simultaneous events:
  - out_ready=1 with a full pipe and in_valid=1: the pipe shifts, the output is consumed and the new input is taken, all in the same cycle.
  - out_valid=0 with out_ready=0: the pipe still advances.
- Change of `signed_mode` between consecutive vectors: each result uses its own captured mode.

## Structure
- Package `adder_pkg`:
  - `clog2` constant function.
  - Derivation of LEVELS and SUMW.
  - Saturation-bound helper functions for signed and unsigned ranges.
- Sub-module `adder_tree_level`:
  - One registered reduction level.
  - Parameters: input count and SUMW.
  - Inputs: enable and valid.
  - Instantiated LEVELS times in a generate loop.
- Top module: operand extension, handshake and advance logic, output range-check and saturate stage.

## Test plan
- Defaults, unsigned: `ops`={0x555,0x456,0x654}, out_ready=1 → after 3 cycles, `y`=0x0FFF, `ovf`=0.
- Unsigned wrap with `SATURATE`=0: three operands of 0xFFFF → `y`=0xFFFD, `ovf`=1. With `SATURATE`=1 → `y`=0xFFFF, `ovf`=1.
- Signed with `SATURATE`=1:
  - {0x7FFF,0x0001,0x0000} → `y`=0x7FFF, `ovf`=1.
  - {0x8000,0xFFFF,0x0000} → `y`=0x8000, `ovf`=1.
  - {0xFFFF,0x0002,0x0000} → `y`=0x0001, `ovf`=0.
- Back-pressure:
  - Stream 8 vectors with out_ready low for cycles 4-7 → `in_ready`=0 during the stall.
  - `y` holds through the stall.
  - All 8 results arrive in order with no loss or duplication.
- Reset mid-stream: assert `rst` for 1 cycle with 3 vectors in flight → out_valid stays 0 until new vectors are accepted. The next result has latency 3.
- Parametric run, `WIDTH`=8, `N_OPS`=5, random signed and unsigned vectors → each result matches a reference model at a latency of 4 cycles.
